// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Gateway bit positions are common to the stall and flash vectors.
package pipe_ctrl_pkg;

    typedef logic bool_t;
    localparam bool_t TRUE  = 1'b1;
    localparam bool_t FALSE = 1'b0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } ctrl_state_t;

    localparam int GW_IF_ID  = 0;
    localparam int GW_ID_EX  = 1;
    localparam int GW_EX_MEM = 2;
    localparam int GW_MEM_WB = 3;

    typedef struct packed {
        logic       pc_stall;
        logic [3:0] stall;
        logic [3:0] flash;
    } gw_ctrl_t;

    // The oldest stalled stage wins: everything younger holds and a bubble
    // is inserted into the gateway right after the stalled stage.
    function automatic gw_ctrl_t stall_decode(input logic [3:0] req);
        gw_ctrl_t d;
        d = '0;
        if (req[3]) begin
            d.pc_stall           = 1'b1;
            d.stall              = 4'b0111;
            d.flash[GW_MEM_WB]   = 1'b1;
        end else if (req[2]) begin
            d.pc_stall           = 1'b1;
            d.stall              = 4'b0011;
            d.flash[GW_EX_MEM]   = 1'b1;
        end else if (req[1]) begin
            d.pc_stall           = 1'b1;
            d.stall              = 4'b0001;
            d.flash[GW_ID_EX]    = 1'b1;
        end else if (req[0]) begin
            d.pc_stall           = 1'b1;
            d.stall              = 4'b0000;
            d.flash[GW_IF_ID]    = 1'b1;
        end else begin
            d = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive PC-hold cycles and raises a sticky flag once the
// count reaches WD_LIMIT.
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int WD_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pc_stall,
    output logic wd_timeout
);

    localparam int CNT_W = $clog2(WD_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WD_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             timeout_r;

    // Next count: clear on any free-running cycle, saturate at the limit.
    always_comb begin
        count_next_s = count_r;
        if (!pc_stall) begin
            count_next_s = '0;
        end else if (count_r == LIMIT_C) begin
            count_next_s = count_r;
        end else begin
            count_next_s = count_r + ONE_C;
        end
    end

    // Counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= '0;
            timeout_r <= FALSE;
        end else begin
            count_r   <= count_next_s;
            timeout_r <= timeout_r | (count_next_s == LIMIT_C);
        end
    end

    assign wd_timeout = timeout_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: per-gateway stall/flash, PC hold,
// fetch redirect on mispredict/exception, and a stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WD_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_if_stall,
    input  logic              req_id_stall,
    input  logic              req_ex_stall,
    input  logic              req_mem_stall,
    input  logic              br_mispredict,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic              fetch_ready,
    output logic              pc_stall,
    output logic [3:0]        stall,
    output logic [3:0]        flash,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              wd_timeout
);

    ctrl_state_t       state_r;
    ctrl_state_t       state_next_s;
    gw_ctrl_t          dec_s;
    logic [3:0]        flash_s;
    logic              pc_stall_s;
    bool_t             latch_s;
    logic [ADDR_W-1:0] latch_pc_s;
    logic              redirect_valid_r;
    logic [ADDR_W-1:0] redirect_pc_r;

    // Stall decode, event resolution and next-state selection.
    always_comb begin
        dec_s        = stall_decode({req_mem_stall, req_ex_stall,
                                     req_id_stall, req_if_stall});
        state_next_s = state_r;
        flash_s      = dec_s.flash;
        pc_stall_s   = dec_s.pc_stall;
        latch_s      = FALSE;
        latch_pc_s   = '0;

        case (state_r)
            RUN: begin
                if (exc_valid) begin
                    latch_s    = TRUE;
                    latch_pc_s = exc_pc;
                    if (req_mem_stall) begin
                        state_next_s = DRAIN;
                    end else begin
                        flash_s      = 4'b1111;
                        state_next_s = REDIR;
                    end
                end else if (br_mispredict && !req_ex_stall && !req_mem_stall) begin
                    flash_s[GW_ID_EX:GW_IF_ID] = 2'b11;
                    latch_s      = TRUE;
                    latch_pc_s   = br_target;
                    state_next_s = REDIR;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                // Hold off the full flush until the dcache transaction retires.
                if (!req_mem_stall) begin
                    flash_s      = 4'b1111;
                    state_next_s = REDIR;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            REDIR: begin
                pc_stall_s         = 1'b1;
                flash_s[GW_IF_ID]  = 1'b1;
                if (exc_valid) begin
                    latch_s    = TRUE;
                    latch_pc_s = exc_pc;
                    flash_s    = 4'b1111;
                    if (req_mem_stall) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s = REDIR;
                    end
                end else if (fetch_ready) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = REDIR;
                end
            end
            default: begin
                flash_s      = 4'b1111;
                pc_stall_s   = 1'b1;
                state_next_s = RUN;
            end
        endcase

        // Keep the whole pipe flushed and the PC frozen while in reset.
        if (!rst_n) begin
            flash_s    = 4'b1111;
            pc_stall_s = 1'b1;
        end else begin
            pc_stall_s = pc_stall_s;
        end
    end

    // State, redirect request and latched redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= RUN;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
        end else begin
            state_r          <= state_next_s;
            redirect_valid_r <= (state_next_s == REDIR);
            if (latch_s) begin
                redirect_pc_r <= latch_pc_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    pipe_ctrl_stall_watchdog #(
        .WD_LIMIT (WD_LIMIT)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_stall   (pc_stall_s),
        .wd_timeout (wd_timeout)
    );

    assign flash          = flash_s;
    assign stall          = dec_s.stall & ~flash_s;
    assign pc_stall       = pc_stall_s;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; inputs change and outputs are sampled
// just after each falling edge, away from the active rising edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_if_stall;
    logic        req_id_stall;
    logic        req_ex_stall;
    logic        req_mem_stall;
    logic        br_mispredict;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        fetch_ready;
    logic        pc_stall;
    logic [3:0]  stall;
    logic [3:0]  flash;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wd_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(
        .ADDR_W   (32),
        .WD_LIMIT (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_if_stall   (req_if_stall),
        .req_id_stall   (req_id_stall),
        .req_ex_stall   (req_ex_stall),
        .req_mem_stall  (req_mem_stall),
        .br_mispredict  (br_mispredict),
        .br_target      (br_target),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .fetch_ready    (fetch_ready),
        .pc_stall       (pc_stall),
        .stall          (stall),
        .flash          (flash),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wd_timeout     (wd_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_comb(input string tag, input logic pcs, input logic [3:0] st,
                            input logic [3:0] fl);
        chk({tag, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, pcs});
        chk({tag, ".stall"},    {28'd0, stall},    {28'd0, st});
        chk({tag, ".flash"},    {28'd0, flash},    {28'd0, fl});
    endtask

    task automatic chk_rv(input string tag, input logic rv);
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
    endtask

    task automatic chk_rpc(input string tag, input logic [31:0] rpc);
        chk({tag, ".redirect_pc"}, redirect_pc, rpc);
    endtask

    task automatic chk_wd(input string tag, input logic wd);
        chk({tag, ".wd_timeout"}, {31'd0, wd_timeout}, {31'd0, wd});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end of sequence");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; req_if_stall = 1'b0; req_id_stall = 1'b0; req_ex_stall = 1'b0;
        req_mem_stall = 1'b0; br_mispredict = 1'b0; br_target = 32'd0;
        exc_valid = 1'b0; exc_pc = 32'd0; fetch_ready = 1'b0;

        // Reset state
        #2;
        chk_comb("reset", 1'b1, 4'b0000, 4'b1111);
        chk_rv("reset", 1'b0); chk_rpc("reset", 32'd0); chk_wd("reset", 1'b0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk_comb("idle", 1'b0, 4'b0000, 4'b0000);
        chk_rv("idle", 1'b0);

        // EX stall for three cycles, then release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req_ex_stall = 1'b1; #1;
            chk_comb("ex_stall", 1'b1, 4'b0011, 4'b0100);
            chk_rv("ex_stall", 1'b0);
        end
        @(negedge clk); req_ex_stall = 1'b0; #1;
        chk_comb("ex_release", 1'b0, 4'b0000, 4'b0000);
        chk_rv("ex_release", 1'b0); chk_wd("ex_release", 1'b0);

        // Mispredict while EX stalled is ignored
        @(negedge clk); req_ex_stall = 1'b1; br_mispredict = 1'b1; br_target = 32'h0000_0BAD; #1;
        chk_comb("br_ex_busy", 1'b1, 4'b0011, 4'b0100);
        @(negedge clk); req_ex_stall = 1'b0; br_mispredict = 1'b0; #1;
        chk_comb("br_ignored", 1'b0, 4'b0000, 4'b0000);
        chk_rv("br_ignored", 1'b0); chk_rpc("br_ignored", 32'd0);

        // Mispredict with redirect held two cycles
        @(negedge clk); br_mispredict = 1'b1; br_target = 32'h0040_0100; #1;
        chk_comb("br_flush", 1'b0, 4'b0000, 4'b0011);
        chk_rv("br_flush", 1'b0);
        @(negedge clk); br_mispredict = 1'b0; br_target = 32'hDEAD_BEEF; #1;
        chk_comb("br_redir1", 1'b1, 4'b0000, 4'b0001);
        chk_rv("br_redir1", 1'b1); chk_rpc("br_redir1", 32'h0040_0100);
        @(negedge clk); #1;
        chk_comb("br_redir2", 1'b1, 4'b0000, 4'b0001);
        chk_rv("br_redir2", 1'b1); chk_rpc("br_redir2", 32'h0040_0100);
        @(negedge clk); fetch_ready = 1'b1; #1;
        chk_rv("br_accept", 1'b1); chk_rpc("br_accept", 32'h0040_0100);
        @(negedge clk); fetch_ready = 1'b0; #1;
        chk_comb("br_run", 1'b0, 4'b0000, 4'b0000);
        chk_rv("br_run", 1'b0);

        // Exception while the dcache is busy: drain first, then full flush
        @(negedge clk); exc_valid = 1'b1; exc_pc = 32'hBFC0_0380; req_mem_stall = 1'b1; #1;
        chk_comb("exc_mem1", 1'b1, 4'b0111, 4'b1000);
        chk_rv("exc_mem1", 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); exc_valid = 1'b0; br_mispredict = (i == 1); br_target = 32'hDEAD_0000; #1;
            chk_comb("exc_drain", 1'b1, 4'b0111, 4'b1000);
            chk_rv("exc_drain", 1'b0);
        end
        @(negedge clk); req_mem_stall = 1'b0; br_mispredict = 1'b0; #1;
        chk("exc_drain_done.flash", {28'd0, flash}, 32'h0000_000F);
        chk("exc_drain_done.stall", {28'd0, stall}, 32'd0);
        chk_rv("exc_drain_done", 1'b0);
        @(negedge clk); fetch_ready = 1'b1; #1;
        chk_comb("exc_redir", 1'b1, 4'b0000, 4'b0001);
        chk_rv("exc_redir", 1'b1); chk_rpc("exc_redir", 32'hBFC0_0380);
        @(negedge clk); fetch_ready = 1'b0; #1;
        chk_rv("exc_run", 1'b0);
        chk_comb("exc_run", 1'b0, 4'b0000, 4'b0000);

        // Same-cycle exception and mispredict: exception wins
        @(negedge clk); exc_valid = 1'b1; exc_pc = 32'h8000_0180;
        br_mispredict = 1'b1; br_target = 32'h1234_5678; #1;
        chk("both.flash", {28'd0, flash}, 32'h0000_000F);
        chk("both.stall", {28'd0, stall}, 32'd0);
        @(negedge clk); exc_valid = 1'b0; br_mispredict = 1'b0; fetch_ready = 1'b1; #1;
        chk_rv("both_redir", 1'b1); chk_rpc("both_redir", 32'h8000_0180);
        @(negedge clk); fetch_ready = 1'b0; #1;
        chk_rv("both_run", 1'b0); chk_rpc("both_run", 32'h8000_0180);

        // Exception arriving while a branch redirect is pending
        @(negedge clk); br_mispredict = 1'b1; br_target = 32'h0000_2000; #1;
        chk("redir_exc_br.flash", {28'd0, flash}, 32'h0000_0003);
        @(negedge clk); br_mispredict = 1'b0; exc_valid = 1'b1; exc_pc = 32'hBFC0_0200; #1;
        chk_comb("redir_exc", 1'b1, 4'b0000, 4'b1111);
        chk_rv("redir_exc", 1'b1); chk_rpc("redir_exc", 32'h0000_2000);
        @(negedge clk); exc_valid = 1'b0; fetch_ready = 1'b1; #1;
        chk_comb("redir_exc_new", 1'b1, 4'b0000, 4'b0001);
        chk_rv("redir_exc_new", 1'b1); chk_rpc("redir_exc_new", 32'hBFC0_0200);
        @(negedge clk); fetch_ready = 1'b0; #1;
        chk_rv("redir_exc_run", 1'b0);

        // Watchdog: IF stall held ten cycles with an 8-cycle limit
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); req_if_stall = 1'b1; #1;
            chk_comb("wd_stall", 1'b1, 4'b0000, 4'b0001);
            chk_wd("wd_stall", (i >= 9));
        end
        @(negedge clk); req_if_stall = 1'b0; #1;
        chk_comb("wd_release", 1'b0, 4'b0000, 4'b0000);
        chk_wd("wd_release", 1'b1);
        @(negedge clk); #1;
        chk_wd("wd_sticky", 1'b1);

        // Reset pulse in the middle of a stall
        @(negedge clk); req_if_stall = 1'b1; #1;
        chk_wd("wd_pre_rst", 1'b1);
        #2; rst_n = 1'b0; #1;
        chk_comb("rst_mid_stall", 1'b1, 4'b0000, 4'b1111);
        chk_wd("rst_mid_stall", 1'b0); chk_rv("rst_mid_stall", 1'b0);
        @(negedge clk); rst_n = 1'b1; req_if_stall = 1'b0; #1;
        chk_comb("rst_release", 1'b0, 4'b0000, 4'b0000);
        chk_wd("rst_release", 1'b0);

        // Reset during REDIR discards the pending target
        @(negedge clk); br_mispredict = 1'b1; br_target = 32'h0000_7000; #1;
        chk("rst_redir_br.flash", {28'd0, flash}, 32'h0000_0003);
        @(negedge clk); br_mispredict = 1'b0; #1;
        chk_rv("rst_redir_pre", 1'b1); chk_rpc("rst_redir_pre", 32'h0000_7000);
        #2; rst_n = 1'b0; #1;
        chk_rv("rst_redir", 1'b0); chk_rpc("rst_redir", 32'd0);
        chk_comb("rst_redir", 1'b1, 4'b0000, 4'b1111);
        @(negedge clk); rst_n = 1'b1; #1;
        chk_comb("rst_redir_after", 1'b0, 4'b0000, 4'b0000);
        @(negedge clk); #1;
        chk_rv("rst_redir_run", 1'b0); chk_rpc("rst_redir_run", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the five-stage dual-issue pipeline.
- Drives the stall and flash inputs of the four gateway registers: if_to_id, id_to_ex, ex_to_mem, mem_to_wb.
- Drives the PC hold and the fetch redirect.
- Resolves stage stall requests, branch mispredicts and exceptions, with exceptions having priority. A watchdog flags stalls that never clear.

Parameters:
- ADDR_W, 32: PC / redirect address width.
- WD_LIMIT, 1024: consecutive stalled cycles before wd_timeout sets.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_if_stall  in  1  icache miss in IF
- req_id_stall  in  1  load-use hazard in ID
- req_ex_stall  in  1  mult/div busy in EX
- req_mem_stall  in  1  dcache transaction outstanding in MEM
- br_mispredict  in  1  EX resolved a mispredicted branch
- br_target  in  ADDR_W  correct branch target
- exc_valid  in  1  MEM raises exception/eret
- exc_pc  in  ADDR_W  handler or EPC target
- fetch_ready  in  1  IF accepts redirect this cycle
- pc_stall  out  1  hold PC register
- stall  out  4  per-gateway stall; bit0=if_to_id … bit3=mem_to_wb
- flash  out  4  per-gateway flush, same indexing
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  ADDR_W  redirect address
- wd_timeout  out  1  sticky watchdog flag

Behaviour:
- Scope per gateway: each stall/flash bit applies to both issue slots of that gateway.
- Gateway priority: flash overrides stall inside each gateway. The controller may assert both on the same bit.
- Timing: stall, flash and pc_stall are combinational from the current requests and state (same-cycle effect). redirect_valid, redirect_pc and wd_timeout are registered.
- Stall decode: the highest (youngest-to-retire) requesting stage k wins. Stages indexed IF=0, ID=1, EX=2, MEM=3.
  - pc_stall=1.
  - stall[j]=1 for all j<k.
  - flash[k]=1 (bubble inserted after stage k).
  - Example: EX stall gives pc_stall=1, stall=4'b0011, flash=4'b0100. IF stall gives pc_stall=1, stall=0, flash=4'b0001.
- FSM states: RUN, DRAIN, REDIR.
- RUN:
  - exc_valid && req_mem_stall: latch exc_pc, go to DRAIN.
  - exc_valid && !req_mem_stall: flash=4'b1111, latch exc_pc, go to REDIR.
  - Else if br_mispredict && !req_ex_stall && !req_mem_stall: flash[1:0]=2'b11, latch br_target, go to REDIR.
  - A mispredict while EX or MEM is stalled is ignored; EX re-presents it once unstalled.
- DRAIN:
  - Normal stall decode continues. exc_valid and br_mispredict are ignored.
  - When req_mem_stall falls: flash=4'b1111, go to REDIR.
- REDIR:
  - redirect_valid=1, redirect_pc=latched target.
  - pc_stall=1 and flash[0]=1 every cycle, so no wrong-path instruction enters ID.
  - fetch_ready → go to RUN; redirect_valid drops on the next edge.
  - exc_valid in REDIR overrides the pending target: re-latch exc_pc and flash=4'b1111. Stay in REDIR, or go to DRAIN if req_mem_stall.
  - br_mispredict in REDIR is ignored.
- Simultaneous events: exception beats mispredict beats stall decode. Flushed gateways override stall bits.
- Watchdog:
  - Counter increments each cycle pc_stall=1 and clears when pc_stall=0. It saturates at WD_LIMIT.
  - wd_timeout sets when the count reaches WD_LIMIT and stays set until reset.
- Reset (rst_n low, asynchronous):
  - state=RUN, redirect_valid=0, redirect_pc=0, counter=0, wd_timeout=0.
  - While rst_n is low, combinational outputs are flash=4'b1111, stall=0, pc_stall=1.
  - Reset mid-DRAIN or mid-REDIR discards the latched target.

Decomposition:
- Shared package (defines.svh):
  - ctrl_state_t enum {RUN, DRAIN, REDIR}.
  - Gateway index constants GW_IF_ID=0, GW_ID_EX=1, GW_EX_MEM=2, GW_MEM_WB=3.
  - Existing bool / `true / `false.
- Sub-module stall_watchdog (clk, rst_n, pc_stall, wd_timeout; parameter WD_LIMIT).
- Stall decode and FSM stay in pipe_ctrl.

Test Plan:
- EX stall only: req_ex_stall=1 for 3 cycles → pc_stall=1, stall=4'b0011, flash=4'b0100 each cycle; all outputs 0 after release.
- Mispredict: br_mispredict=1, br_target=32'h0040_0100 → same cycle flash=4'b0011. Next cycle redirect_valid=1 with redirect_pc=32'h0040_0100, held for 2 cycles with fetch_ready=0; state returns to RUN the cycle after fetch_ready=1.
- Exception with dcache busy: exc_valid=1, exc_pc=32'hBFC0_0380, req_mem_stall=1 for 4 cycles → no full flush during DRAIN; flash=4'b1111 on the cycle req_mem_stall falls; then redirect_valid=1 with pc=32'hBFC0_0380.
- Same-cycle exc_valid and br_mispredict → flash=4'b1111 and redirect_pc=exc_pc; br_target is never presented.
- Exception during REDIR (branch target pending) → redirect_pc switches to exc_pc the next cycle, flash=4'b1111.
- WD_LIMIT=8, req_if_stall held 10 cycles → wd_timeout rises after the 8th stalled cycle and stays 1 after release; rst_n pulse low mid-stall → immediate flash=4'b1111, wd_timeout=0.
